// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF to ID pipeline register with 2-entry skid buffer, flush and perf counters
module if_id_skid_stage #(
   parameter int PC_W    = 12,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    pc_4,
   input  logic [INSTR_W-1:0] instruction,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pc_4_out,
   output logic [INSTR_W-1:0] instruction_out,
   input  logic               flush,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic               in_ready_q;
   logic               accept;
   logic [PC_W-1:0]    main_pc;
   logic [INSTR_W-1:0] main_instr;
   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // An entry is only taken when the registered ready was high at this edge.
   assign accept = in_valid & in_ready_q;

   // Next-state decode; flush overrides every other transition.
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) next_state = FULL;
            FULL: begin
               if (accept && !out_ready)      next_state = SKID;
               else if (!accept && out_ready) next_state = EMPTY;
            end
            SKID:    if (out_ready) next_state = FULL;
            default: next_state = EMPTY;
         endcase
      end
   end

   // State, registered ready and entry payloads; the skid entry refills main when decode drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b0;
         main_pc    <= '0;
         main_instr <= '0;
         skid_pc    <= '0;
         skid_instr <= '0;
      end else begin
         state      <= next_state;
         in_ready_q <= (next_state != SKID);
         if (flush) begin
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
         end else begin
            case (state)
               EMPTY: begin
                  if (accept) begin
                     main_pc    <= pc_4;
                     main_instr <= instruction;
                  end
               end
               FULL: begin
                  if (accept && out_ready) begin
                     main_pc    <= pc_4;
                     main_instr <= instruction;
                  end else if (accept) begin
                     skid_pc    <= pc_4;
                     skid_instr <= instruction;
                  end
               end
               SKID: begin
                  if (out_ready) begin
                     main_pc    <= skid_pc;
                     main_instr <= skid_instr;
                     skid_pc    <= '0;
                     skid_instr <= '0;
                  end
               end
               default: begin
                  main_pc    <= '0;
                  main_instr <= '0;
               end
            endcase
         end
      end
   end

   // Saturating performance counters; clear wins over any increment in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = (state != EMPTY);
   assign pc_4_out        = out_valid ? main_pc : '0;
   assign instruction_out = out_valid ? main_instr : '0;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed self-checking bench for if_id_skid_stage
module tb_if_id_skid_stage;

   localparam int PC_W    = 12;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 4;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    pc_4;
   logic [INSTR_W-1:0] instruction;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    pc_4_out;
   logic [INSTR_W-1:0] instruction_out;
   logic               flush;
   logic               cnt_clr;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;

   int n_cmp;
   int n_bad;

   if_id_skid_stage #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .pc_4            (pc_4),
      .instruction     (instruction),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .pc_4_out        (pc_4_out),
      .instruction_out (instruction_out),
      .flush           (flush),
      .cnt_clr         (cnt_clr),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      pc_4        = '0;
      instruction = '0;
      out_ready   = 1'b0;
      flush       = 1'b0;
      cnt_clr     = 1'b0;

      // 1: reset values, release, first entry
      #2;
      chk("rst_in_ready",  64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_pc_out",    64'(pc_4_out), 64'd0);
      chk("rst_instr_out", 64'(instruction_out), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
      in_valid    = 1'b1;
      pc_4        = 12'h004;
      instruction = 32'h2008_0005;
      out_ready   = 1'b1;
      tick();
      chk("rst_held_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      tick();
      chk("rel_in_ready",  64'(in_ready), 64'd1);
      chk("rel_out_valid", 64'(out_valid), 64'd0);
      tick();
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_pc",    64'(pc_4_out), 64'h004);
      chk("first_instr", 64'(instruction_out), 64'h2008_0005);
      in_valid = 1'b0;
      tick();
      chk("first_drain", 64'(out_valid), 64'd0);

      // 2: streaming 8 entries
      for (int i = 0; i < 8; i++) begin
         in_valid    = 1'b1;
         pc_4        = 12'(4 * (i + 1));
         instruction = 32'h1000_0000 + 32'(i);
         tick();
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_pc",    64'(pc_4_out), 64'(4 * (i + 1)));
         chk("stream_instr", 64'(instruction_out), 64'h1000_0000 + 64'(i));
         chk("stream_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 64'(out_valid), 64'd0);
      chk("stream_stall", 64'(stall_cnt), 64'd0);

      // 3: backpressure into the skid entry
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      pc_4        = 12'h004;
      instruction = 32'hAAAA_0004;
      tick();
      chk("bp_full_pc", 64'(pc_4_out), 64'h004);
      chk("bp_full_stall", 64'(stall_cnt), 64'd0);
      pc_4        = 12'h008;
      instruction = 32'hAAAA_0008;
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stall1",   64'(stall_cnt), 64'd1);
      in_valid = 1'b0;
      tick();
      tick();
      chk("bp_stall3",    64'(stall_cnt), 64'd3);
      chk("bp_hold_pc",   64'(pc_4_out), 64'h004);
      chk("bp_hold_inst", 64'(instruction_out), 64'hAAAA_0004);
      out_ready = 1'b1;
      tick();
      chk("bp_second_pc",    64'(pc_4_out), 64'h008);
      chk("bp_second_instr", 64'(instruction_out), 64'hAAAA_0008);
      chk("bp_ready_back",   64'(in_ready), 64'd1);
      chk("bp_stall_final",  64'(stall_cnt), 64'd3);
      tick();
      chk("bp_drain", 64'(out_valid), 64'd0);

      // 4: flush with both entries valid and a new input presented
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      pc_4        = 12'h010;
      instruction = 32'hBBBB_0010;
      tick();
      pc_4        = 12'h014;
      instruction = 32'hBBBB_0014;
      tick();
      chk("fl_skid_ready", 64'(in_ready), 64'd0);
      chk("fl_pre_stall",  64'(stall_cnt), 64'd4);
      pc_4        = 12'h00C;
      instruction = 32'hCCCC_000C;
      flush       = 1'b1;
      tick();
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_pc",        64'(pc_4_out), 64'd0);
      chk("fl_instr",     64'(instruction_out), 64'd0);
      chk("fl_in_ready",  64'(in_ready), 64'd1);
      chk("fl_cnt",       64'(flush_cnt), 64'd1);
      chk("fl_stall",     64'(stall_cnt), 64'd4);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_no_ghost", 64'(out_valid), 64'd0);
      end

      // 5: counter saturation and clear
      cnt_clr = 1'b1;
      tick();
      chk("clr_stall", 64'(stall_cnt), 64'd0);
      chk("clr_flush", 64'(flush_cnt), 64'd0);
      cnt_clr     = 1'b0;
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      pc_4        = 12'h024;
      instruction = 32'hDDDD_0024;
      tick();
      in_valid = 1'b0;
      chk("sat_start", 64'(stall_cnt), 64'd0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_15", 64'(stall_cnt), 64'd15);
      tick();
      chk("sat_hold", 64'(stall_cnt), 64'd15);
      cnt_clr = 1'b1;
      tick();
      chk("sat_clr", 64'(stall_cnt), 64'd0);
      cnt_clr = 1'b0;
      tick();
      chk("sat_restart", 64'(stall_cnt), 64'd1);

      // 6: asynchronous reset while in SKID
      in_valid    = 1'b1;
      pc_4        = 12'h028;
      instruction = 32'hDDDD_0028;
      tick();
      chk("ar_skid_ready", 64'(in_ready), 64'd0);
      chk("ar_skid_valid", 64'(out_valid), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_in_ready",  64'(in_ready), 64'd0);
      chk("ar_stall",     64'(stall_cnt), 64'd0);
      chk("ar_flush",     64'(flush_cnt), 64'd0);
      chk("ar_pc",        64'(pc_4_out), 64'd0);
      tick();
      rst         = 1'b0;
      in_valid    = 1'b1;
      pc_4        = 12'h040;
      instruction = 32'hEEEE_0040;
      out_ready   = 1'b1;
      tick();
      chk("ar_rel_ready", 64'(in_ready), 64'd1);
      chk("ar_rel_valid", 64'(out_valid), 64'd0);
      tick();
      chk("ar_new_valid", 64'(out_valid), 64'd1);
      chk("ar_new_pc",    64'(pc_4_out), 64'h040);
      chk("ar_new_instr", 64'(instruction_out), 64'hEEEE_0040);
      in_valid = 1'b0;
      tick();
      chk("ar_no_stale", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF→ID pipeline stage register with a ready/valid handshake on both sides.
- A 2-entry skid buffer registers the upstream ready, so a decode stall never forms a combinational path back to fetch.
- Synchronous flush turns the stage into a bubble (zero PC, zero/NOP instruction).
- Saturating stall and flush counters support performance debug.

Parameters:
PC_W, 12, width of the PC+4 field
INSTR_W, 32, width of the instruction field
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  fetch presents a valid pc_4/instruction
in_ready  output  1  stage can accept (registered)
pc_4  input  PC_W  incoming PC+4
instruction  input  INSTR_W  incoming instruction
out_valid  output  1  decode sees a valid entry
out_ready  input  1  decode consumes the entry this cycle
pc_4_out  output  PC_W  PC+4 to decode
instruction_out  output  INSTR_W  instruction to decode
flush  input  1  synchronous clear of all entries (branch/jump taken)
cnt_clr  input  1  synchronous clear of both counters
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
flush_cnt  output  CNT_W  cycles with flush=1

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-high.
- While rst=1, all of the following hold:
  - state=EMPTY; main and skid entries invalid, payloads zero.
  - in_ready=0, out_valid=0, pc_4_out=0, instruction_out=0.
  - stall_cnt=0, flush_cnt=0.
- First rising edge after rst falls: in_ready→1.
- Transfer definitions:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- States: EMPTY (no entry), FULL (main valid), SKID (main and skid valid).
- out_valid = (state≠EMPTY). It is a decode of registered state only; there is no combinational path from any input.
- in_ready is a register, loaded each edge with (next_state≠SKID).
- Transitions when flush=0:
  - EMPTY: in_valid → main←input, go FULL; else stay EMPTY.
  - FULL, in_valid & out_ready → main←input, stay FULL (1 entry/cycle throughput).
  - FULL, !in_valid & out_ready → EMPTY.
  - FULL, in_valid & !out_ready → skid←input, go SKID.
  - FULL, !in_valid & !out_ready → hold.
  - SKID (in_ready=0, input ignored): out_ready → main←skid, skid invalid, go FULL; else hold.
- Latency: input accepted at edge N appears on outputs after edge N (one cycle) when the stage was EMPTY, or FULL with out_ready=1.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- Flush (flush=1 at an edge) has priority over every transition:
  - Both entries invalidated; state→EMPTY; in_ready→1.
  - Payload registers zeroed.
  - Any input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as consumed by decode.
- Output payload: pc_4_out/instruction_out are driven from the main entry when out_valid=1, and are forced to 0 when out_valid=0.
- Counters:
  - stall_cnt increments on each edge with out_valid=1, out_ready=0, flush=0.
  - flush_cnt increments on each edge with flush=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
  - cnt_clr=1 zeroes both at the edge and beats any increment in the same cycle.
- Reset asserted mid-operation: outputs take reset values immediately (asynchronously); pending entries are lost.

Test Plan:
1. Reset release, then in_valid=1, pc_4=0x004, instruction=0x2008_0005, out_ready=1:
   - in_ready=0 during reset and 1 one edge after release.
   - out_valid=1 with pc_4_out=0x004, instruction_out=0x2008_0005 one edge after acceptance.
2. Streaming: 8 back-to-back entries (pc_4=0x004..0x020), out_ready=1 throughout:
   - 8 outputs in order on consecutive cycles.
   - in_ready stays 1; stall_cnt=0.
3. Backpressure: stage FULL with 0x004, out_ready=0, new input 0x008 accepted:
   - in_ready=0 at the next edge.
   - After 3 stalled cycles, out_ready=1 yields 0x004 then 0x008.
   - stall_cnt=3 (counting starts at the first stalled edge).
4. Flush with both entries valid and in_valid=1 presenting 0x00C:
   - Next cycle out_valid=0, pc_4_out=0, instruction_out=0, in_ready=1.
   - 0x00C is never output; flush_cnt=1.
5. Counter saturation with CNT_W=4: hold out_ready=0 for 20 cycles:
   - stall_cnt=15 and stays at 15.
   - cnt_clr=1 with the stall continuing → stall_cnt=0 at that edge.
6. rst asserted asynchronously mid-stream, between clock edges, while in SKID:
   - out_valid, in_ready and both counters go to 0 immediately.
   - After release, the first accepted entry is output correctly with no stale data.
